// File: rtl/tmds_symbol_decoder_pkg.sv
// Shared TMDS receive types: control token codes, symbol/pixel types, alignment FSM states.
// Pure definitions; no clocked logic.
package tmds_pkg;

  typedef logic [9:0] tmds_sym_t;
  typedef logic [7:0] tmds_pix_t;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tmds_state_t;

  localparam tmds_sym_t TOK_C00 = 10'h354;
  localparam tmds_sym_t TOK_C01 = 10'h0AB;
  localparam tmds_sym_t TOK_C10 = 10'h154;
  localparam tmds_sym_t TOK_C11 = 10'h2AB;

  function automatic logic tmds_is_token(input tmds_sym_t s);
    return (s == TOK_C00) || (s == TOK_C01) || (s == TOK_C10) || (s == TOK_C11);
  endfunction

  function automatic logic [1:0] tmds_ctrl_of(input tmds_sym_t s);
    logic [1:0] c;
    case (s)
      TOK_C01: c = 2'b01;
      TOK_C10: c = 2'b10;
      TOK_C11: c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tmds_symbol_decoder_align.sv
// Symbol boundary hunt: 20-bit window, SEARCH/LOCKED FSM, dwell/run/gap counters.
// Symbol and token flag are combinational from the window; no backpressure. TMDS_RX_LOSS_CNT_EN adds loss_count.
module tmds_symbol_align
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int SEARCH_DWELL = 2048,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic        i_clk_pixel,
  input  logic        i_rst,
  input  tmds_sym_t   raw,
  output tmds_sym_t   sym,
  output logic        tok,
  output logic        locked,
  output logic [3:0]  offset
`ifdef TMDS_RX_LOSS_CNT_EN
  ,
  output logic [15:0] loss_count
`endif
);

  localparam int RUN_W   = $clog2(LOCK_COUNT);
  localparam int DWELL_W = $clog2(SEARCH_DWELL);
  localparam int GAP_W   = $clog2(LOSS_TIMEOUT);

  tmds_sym_t        prev;
  tmds_state_t      state;
  logic [RUN_W-1:0]   run;
  logic [DWELL_W-1:0] dwell;
  logic [GAP_W-1:0]   gap;
  logic [19:0]        win;

  // bit 0 of prev is the oldest received bit, so shifting right selects later framings
  assign win = {raw, prev};
  assign sym = tmds_sym_t'(win >> offset);
  assign tok = tmds_is_token(sym);

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      prev       <= '0;
      state      <= SEARCH;
      locked     <= 1'b0;
      offset     <= 4'd0;
      run        <= '0;
      dwell      <= '0;
      gap        <= '0;
`ifdef TMDS_RX_LOSS_CNT_EN
      loss_count <= 16'd0;
`endif
    end else begin
      prev <= raw;
      if (state == SEARCH) begin
        // a completed token run wins over a dwell expiry landing on the same cycle
        if (tok && run == RUN_W'(LOCK_COUNT - 1)) begin
          state  <= LOCKED;
          locked <= 1'b1;
          gap    <= '0;
          run    <= '0;
          dwell  <= '0;
        end else if (dwell == DWELL_W'(SEARCH_DWELL - 1)) begin
          offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          dwell  <= '0;
          run    <= '0;
        end else begin
          dwell <= (dwell == '1) ? dwell : dwell + DWELL_W'(1);
          if (tok) run <= (run == '1) ? run : run + RUN_W'(1);
          else     run <= '0;
        end
      end else begin
        if (tok) begin
          gap <= '0;
        end else if (gap == GAP_W'(LOSS_TIMEOUT - 1)) begin
          state  <= SEARCH;
          locked <= 1'b0;
          gap    <= '0;
          dwell  <= '0;
          run    <= '0;
`ifdef TMDS_RX_LOSS_CNT_EN
          if (loss_count != 16'hFFFF) loss_count <= loss_count + 16'd1;
`endif
        end else begin
          gap <= (gap == '1) ? gap : gap + GAP_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tmds_symbol_decoder.sv
// One TMDS channel receiver: word alignment then symbol decode to pixel byte or control value.
// Two registered stages after the alignment window; no backpressure. TMDS_RX_LOSS_CNT_EN adds o_loss_count.
module tmds_symbol_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int SEARCH_DWELL = 2048,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic        i_clk_pixel,
  input  logic        i_rst,
  input  logic [9:0]  i_raw,
  output logic [7:0]  o_data,
  output logic [1:0]  o_ctrl,
  output logic        o_de,
  output logic        o_valid,
  output logic        o_locked,
  output logic [3:0]  o_offset
`ifdef TMDS_RX_LOSS_CNT_EN
  ,
  output logic [15:0] o_loss_count
`endif
);

  tmds_sym_t  sym;
  logic       tok;
  tmds_sym_t  s1_sym;
  logic       s1_tok;
  logic [1:0] s1_ctrl;
  logic       s1_locked;

  function automatic tmds_pix_t tmds_decode(input tmds_sym_t q);
    tmds_pix_t qp;
    tmds_pix_t d;
    qp   = q[9] ? ~q[7:0] : q[7:0];
    d    = '0;
    d[0] = qp[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (qp[i] ^ qp[i-1]) : ~(qp[i] ^ qp[i-1]);
    end
    return d;
  endfunction

  tmds_symbol_align #(
    .LOCK_COUNT  (LOCK_COUNT),
    .SEARCH_DWELL(SEARCH_DWELL),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) u_align (
    .i_clk_pixel(i_clk_pixel),
    .i_rst      (i_rst),
    .raw        (i_raw),
    .sym        (sym),
    .tok        (tok),
    .locked     (o_locked),
    .offset     (o_offset)
`ifdef TMDS_RX_LOSS_CNT_EN
    ,
    .loss_count (o_loss_count)
`endif
  );

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      s1_sym    <= '0;
      s1_tok    <= 1'b0;
      s1_ctrl   <= 2'b00;
      s1_locked <= 1'b0;
      o_data    <= '0;
      o_ctrl    <= 2'b00;
      o_de      <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      s1_sym    <= sym;
      s1_tok    <= tok;
      s1_ctrl   <= tmds_ctrl_of(sym);
      s1_locked <= o_locked;
      o_de      <= ~s1_tok;
      o_valid   <= s1_locked;
      // o_ctrl keeps the last control value seen across active video
      if (s1_tok) begin
        o_data <= '0;
        o_ctrl <= s1_ctrl;
      end else begin
        o_data <= tmds_decode(s1_sym);
      end
    end
  end

endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// Directed bench for tmds_symbol_decoder with LOCK_COUNT=4, SEARCH_DWELL=16, LOSS_TIMEOUT=32.
module tb_tmds_symbol_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raw;
  logic [7:0]  data;
  logic [1:0]  ctrl;
  logic        de;
  logic        valid;
  logic        locked;
  logic [3:0]  offset;
`ifdef TMDS_RX_LOSS_CNT_EN
  logic [15:0] loss_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [9:0]  seq_g [9];
  logic [9:0]  drv_d [11];
  logic [15:0] exp_d [9];

  always #5 clk = ~clk;

  tmds_symbol_decoder #(
    .LOCK_COUNT  (4),
    .SEARCH_DWELL(16),
    .LOSS_TIMEOUT(32)
  ) dut (
    .i_clk_pixel (clk),
    .i_rst       (rst),
    .i_raw       (raw),
    .o_data      (data),
    .o_ctrl      (ctrl),
    .o_de        (de),
    .o_valid     (valid),
    .o_locked    (locked),
    .o_offset    (offset)
`ifdef TMDS_RX_LOSS_CNT_EN
    ,
    .o_loss_count(loss_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // 0x2A6 framed stream: true symbol 0x354 sits at window offset 3, so the hunt
  // passes offsets 0..2 (16 cycles each) and locks on the 4th token at offset 3.
  task automatic search_lock(input string tag);
    int         lock_cyc;
    logic [3:0] last_off;
    lock_cyc = -1;
    last_off = 4'd0;
    for (int t = 1; t <= 60 && lock_cyc < 0; t++) begin
      tick();
      if (offset != last_off) begin
        check({tag, " step"}, 16'(offset), 16'(last_off + 4'd1));
        check({tag, " step time"}, 16'(t), 16'(16 * int'(offset)));
        last_off = offset;
      end
      if (locked) lock_cyc = t;
    end
    check({tag, " lock cycle"}, 16'(lock_cyc), 16'd52);
    check({tag, " lock offset"}, 16'(offset), 16'd3);
    check({tag, " valid at lock"}, 16'(valid), 16'd0);
  endtask

  initial begin
    seq_g = '{10'h354, 10'h354, 10'h354, 10'h100, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354};
    drv_d = '{10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h100, 10'h1FF, 10'h3C0, 10'h0F0,
              10'h154, 10'h354, 10'h354};
    // {de, ctrl, data}
    exp_d = '{16'h000, 16'h100, 16'h200, 16'h300, 16'h700, 16'h701, 16'h741, 16'h7EE, 16'h200};

    rst = 1'b1;
    raw = 10'h2A6;
    tick();
    tick();
    check("reset data",   16'(data),   16'd0);
    check("reset ctrl",   16'(ctrl),   16'd0);
    check("reset de",     16'(de),     16'd0);
    check("reset valid",  16'(valid),  16'd0);
    check("reset locked", 16'(locked), 16'd0);
    check("reset offset", 16'(offset), 16'd0);
`ifdef TMDS_RX_LOSS_CNT_EN
    check("reset loss", loss_count, 16'd0);
`endif
    rst = 1'b0;

    search_lock("search");
    tick();
    tick();
    check("lock valid", 16'(valid), 16'd1);
    check("lock de",    16'(de),    16'd0);
    check("lock ctrl",  16'(ctrl),  16'd0);
    check("lock data",  16'(data),  16'd0);

    // 0x15D stream reads as token 0x2AB at offset 3
    raw = 10'h15D;
    tick();
    tick();
    tick();
    check("pre-reset ctrl",   16'(ctrl),   16'd3);
    check("pre-reset locked", 16'(locked), 16'd1);
    check("pre-reset offset", 16'(offset), 16'd3);

    rst = 1'b1;
    tick();
    check("midreset data",   16'(data),   16'd0);
    check("midreset ctrl",   16'(ctrl),   16'd0);
    check("midreset de",     16'(de),     16'd0);
    check("midreset valid",  16'(valid),  16'd0);
    check("midreset locked", 16'(locked), 16'd0);
    check("midreset offset", 16'(offset), 16'd0);
    rst = 1'b0;
    raw = 10'h2A6;
    search_lock("relock");
    tick();
    tick();

    // Loss: every window of the 0x100 stream is a non-token from the first cycle
    raw = 10'h100;
    repeat (31) tick();
    check("loss before expiry", 16'(locked), 16'd1);
    tick();
    check("loss at expiry", 16'(locked), 16'd0);
    check("loss offset",    16'(offset), 16'd3);
`ifdef TMDS_RX_LOSS_CNT_EN
    check("loss count", loss_count, 16'd1);
`endif

    begin : wrap_blk
      int         since;
      logic [3:0] last_off;
      logic       wrapped;
      since    = 0;
      last_off = 4'd3;
      wrapped  = 1'b0;
      for (int t = 0; t < 150 && !wrapped; t++) begin
        tick();
        since++;
        if (offset != last_off) begin
          check("wrap step",  16'(offset), (last_off == 4'd9) ? 16'd0 : 16'(last_off + 4'd1));
          check("wrap dwell", 16'(since),  16'd16);
          wrapped  = (last_off == 4'd9);
          last_off = offset;
          since    = 0;
        end
      end
      check("wrap seen",   16'(wrapped), 16'd1);
      check("wrap offset", 16'(offset),  16'd0);
    end

    // 3 tokens, one data word, 4 tokens: only the uninterrupted run of 4 locks
    for (int j = 0; j < 9; j++) begin
      raw = seq_g[j];
      tick();
      check("run lock", 16'(locked), 16'(j == 8));
    end
    check("run lock offset", 16'(offset), 16'd0);

    // Control and data decode at offset 0; output appears on the 3rd edge after the drive
    for (int t = 0; t < 11; t++) begin
      raw = drv_d[t];
      tick();
      if (t >= 2) begin
        check("decode", {5'b0, de, ctrl, data}, exp_d[t-2]);
        check("decode valid", 16'(valid), 16'd1);
      end
    end
    check("final locked", 16'(locked), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
